fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-domain pointer and flag controller for the asynchronous FIFO. It maintains the binary read pointer and its Gray-coded copy, and synchronises the write-domain Gray pointer into clk. From these it produces a registered empty flag, almost_empty, an occupancy estimate and an underflow pulse. It sits between the read-side client and the dual-port RAM read port. It is the read-end counterpart of the write-side pointer/full logic.

## Interface
Parameters:
- ADDR_WIDTH, 5, RAM address bits; FIFO depth = 2**ADDR_WIDTH.
- AE_THRESH, 2, almost_empty asserts when occupancy <= AE_THRESH.

Ports:
- clk  input  1  read-domain clock.
- rst_n  input  1  reset; asynchronous, active-low.
- rd_en  input  1  read request from client.
- wr_ptr_gray  input  ADDR_WIDTH+1  write pointer, Gray code, from the write clock domain (asynchronous to clk).
- rd_addr  output  ADDR_WIDTH  RAM read address = rd_ptr_bin[ADDR_WIDTH-1:0].
- rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- empty  output  1  registered empty flag.
- almost_empty  output  1  registered; occupancy <= AE_THRESH.
- rd_level  output  ADDR_WIDTH+1  registered occupancy estimate, 0..2**ADDR_WIDTH.
- underflow  output  1  one-cycle pulse when rd_en is sampled while empty=1.

## Operation
- Reset (async assert; release synchronous to clk) sets:
  - rd_ptr_bin = 0, rd_ptr_gray = 0, both sync stages = 0.
  - empty = 1, almost_empty = 1, rd_level = 0, underflow = 0.
- Read accept: rd_inc = rd_en & ~empty.
  - rd_bin_next = rd_ptr_bin + rd_inc, ADDR_WIDTH+1 bits, modulo 2**(ADDR_WIDTH+1). Natural wrap from all-ones to 0.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both pointers register rd_*_next every cycle.
- Synchroniser: two flip-flop stages on wr_ptr_gray. The output is wq2_gray. No other logic touches the asynchronous input.
- empty <= (rd_gray_next == wq2_gray). The flag uses the next pointer, so the read of the last word sets empty on the same edge.
- Occupancy:
  - wq2_bin = gray2bin(wq2_gray).
  - lvl_next = wq2_bin - rd_bin_next, modulo 2**(ADDR_WIDTH+1).
  - rd_level <= lvl_next.
  - almost_empty <= (lvl_next <= AE_THRESH).
- underflow <= rd_en & empty. The pointer does not move on a rejected read.
- Data: the RAM read is combinational from rd_addr. The data word is valid whenever empty = 0, and the client consumes it on the edge where rd_inc = 1.
- Flags are pessimistic: empty may stay asserted up to the synchroniser latency after a write. It never falsely deasserts.

## Timing
- Write-to-visible latency: if wr_ptr_gray changes and is stable before rising edge N:
  - wq2_gray updates at edge N+1.
  - empty, rd_level and almost_empty update at edge N+2.
- Read: when rd_en=1 and empty=0 at edge K, all of the following update at edge K:
  - rd_addr and rd_ptr_gray.
  - empty, if the FIFO is now drained.
  - rd_level, which decrements by 1.
- Underflow: when rd_en=1 and empty=1 at edge K, underflow is high for exactly the cycle after K.
- Back-to-back reads are sustained at one per cycle while empty=0.
- Simultaneous write arrival and read at the same edge: the pointer comparison uses both new values; rd_level nets to the correct value.
- rd_ptr_gray changes by at most one bit per clk edge.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). The write side must be reset together; mismatched reset is outside this block's contract.

## Structure
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width.
  - the default ADDR_WIDTH constant.
- The write-side controller uses the same package.
- Sub-module gray_ptr_sync: a WIDTH-parameterised two-stage synchroniser with async active-low reset. It is reused by the write side for rd_ptr_gray.

## Test plan
Bench uses ADDR_WIDTH=2 (depth 4) and AE_THRESH=1.
- Reset → empty=1, almost_empty=1, rd_level=0, rd_addr=0, rd_ptr_gray=0; rd_en=1 during empty → underflow pulses 1 cycle, rd_addr stays 0.
- Drive wr_ptr_gray=3'b001 (one word) before edge N → empty=0 and rd_level=1 after edge N+2, not earlier; almost_empty stays 1.
- Drive wr_ptr_gray=3'b110 (bin 4, full); hold rd_en=1 for 4 cycles:
  - rd_level steps 4,3,2,1,0.
  - rd_addr steps 0,1,2,3,0.
  - empty asserts on the 4th read edge.
  - no underflow pulse.
- Wrap: loop 10 fill/drain rounds; rd_ptr_bin wraps 7→0. At every edge, rd_ptr_gray Hamming distance from its previous value is ≤1, and empty is correct across the wrap.
- Simultaneous: at rd_level=1, advance wr_ptr_gray by one and read on the same edge → empty never asserts once wq2_gray catches up, and rd_level returns to 1.
- Assert rst_n low while mid-drain with rd_level=3 → outputs reach reset values without a clock edge; reads resume correctly after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read and write pointer controllers.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 5;

    // Widest pointer the helpers handle; narrower pointers are zero-extended in and truncated out.
    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = gray;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_read_ctrl_if.sv
// Read-side client / pointer-exchange bundle of the async FIFO read controller.
interface fifo_read_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEFAULT
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic                  rd_en;
    logic [PTR_W-1:0]      wr_ptr_gray;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PTR_W-1:0]      rd_ptr_gray;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_W-1:0]      rd_level;
    logic                  underflow;

    // Client side: issues reads, supplies the write-domain pointer.
    modport master (
        output rd_en,
        output wr_ptr_gray,
        input  rd_addr,
        input  rd_ptr_gray,
        input  empty,
        input  almost_empty,
        input  rd_level,
        input  underflow
    );

    // Controller side.
    modport slave (
        input  rd_en,
        input  wr_ptr_gray,
        output rd_addr,
        output rd_ptr_gray,
        output empty,
        output almost_empty,
        output rd_level,
        output underflow
    );

endinterface : fifo_read_ctrl_if

// File: rtl/gray_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_ptr_sync #(
    parameter int unsigned WIDTH = fifo_pkg::ADDR_WIDTH_DEFAULT + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    // Only stage1 samples the asynchronous input; q is the settled copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule : gray_ptr_sync

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer and flag controller of the async FIFO.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_read_ctrl_if.slave   bus
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] rd_ptr_bin;
    logic [PTR_W-1:0] rd_ptr_gray_q;
    logic [PTR_W-1:0] wq2_gray;
    logic             empty_q;
    logic             almost_empty_q;
    logic [PTR_W-1:0] rd_level_q;
    logic             underflow_q;

    logic             rd_inc_c;
    logic [PTR_W-1:0] rd_bin_next_c;
    logic [PTR_W-1:0] rd_gray_next_c;
    logic [PTR_W-1:0] wq2_bin_c;
    logic [PTR_W-1:0] lvl_next_c;
    logic             empty_next_c;
    logic             almost_empty_next_c;

    // Bring the write pointer into clk; nothing else looks at wr_ptr_gray.
    gray_ptr_sync #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.wr_ptr_gray),
        .q     (wq2_gray)
    );

    // Next pointer and flag values; flags look at the post-read pointer so the last read sets empty.
    always_comb begin
        rd_inc_c            = bus.rd_en & ~empty_q;
        rd_bin_next_c       = rd_ptr_bin + PTR_W'(rd_inc_c);
        rd_gray_next_c      = PTR_W'(bin2gray(ptr_word_t'(rd_bin_next_c)));
        wq2_bin_c           = PTR_W'(gray2bin(ptr_word_t'(wq2_gray)));
        lvl_next_c          = wq2_bin_c - rd_bin_next_c;
        empty_next_c        = (rd_gray_next_c == wq2_gray);
        almost_empty_next_c = (32'(lvl_next_c) <= AE_THRESH);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_bin    <= '0;
            rd_ptr_gray_q <= '0;
        end else begin
            rd_ptr_bin    <= rd_bin_next_c;
            rd_ptr_gray_q <= rd_gray_next_c;
        end
    end

    // Status flags and occupancy; reset state reads as an empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_level_q     <= '0;
            underflow_q    <= 1'b0;
        end else begin
            empty_q        <= empty_next_c;
            almost_empty_q <= almost_empty_next_c;
            rd_level_q     <= lvl_next_c;
            underflow_q    <= bus.rd_en & empty_q;
        end
    end

    assign bus.rd_addr      = rd_ptr_bin[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray  = rd_ptr_gray_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.underflow    = underflow_q;

endmodule : fifo_read_ctrl

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl with a word-count reference model.
module tb_fifo_read_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned AE = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_read_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_read_ctrl #(
        .ADDR_WIDTH (AW),
        .AE_THRESH  (AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] gray;
        logic          empty;
        logic          ae;
        logic [PW-1:0] level;
        logic          uf;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: totals of words written/read since reset.
    int   wtot;
    int   rd_tot;
    int   w_seen1;   // write total sampled one edge ago
    int   w_seen2;   // write total sampled two edges ago (what the flags may see)
    bit   m_empty;

    function automatic logic [PW-1:0] ref_gray(input int n);
        int b;
        b = n % (2 * DEPTH);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wtot = 0; rd_tot = 0; w_seen1 = 0; w_seen2 = 0; m_empty = 1'b1;
    endtask

    // Drive one cycle of stimulus, predict the state after the next edge, then wait past it.
    task automatic step(input bit re, input int wt);
        exp_t e;
        int   lvl;
        bit   inc;
        bus.rd_en       = re;
        bus.wr_ptr_gray = ref_gray(wt);
        inc     = re && !m_empty;
        e.uf    = re && m_empty;
        rd_tot  = rd_tot + int'(inc);
        lvl     = w_seen2 - rd_tot;
        m_empty = (lvl == 0);
        e.empty = m_empty;
        e.ae    = (lvl <= int'(AE));
        e.level = PW'(lvl);
        e.addr  = AW'(rd_tot % DEPTH);
        e.gray  = ref_gray(rd_tot);
        sbq.push_back(e);
        w_seen2 = w_seen1;
        w_seen1 = wt;
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_ae"},    32'(bus.almost_empty), 32'd1);
        check({tag, "_level"}, 32'(bus.rd_level), 32'd0);
        check({tag, "_addr"},  32'(bus.rd_addr), 32'd0);
        check({tag, "_gray"},  32'(bus.rd_ptr_gray), 32'd0);
        check({tag, "_uf"},    32'(bus.underflow), 32'd0);
    endtask

    // Monitor: pops one prediction per edge and compares; also checks Gray single-bit steps.
    initial begin
        logic [PW-1:0] prev_gray;
        exp_t          e;
        prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_gray = '0;
                sbq.delete();
            end else if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("rd_addr",      32'(bus.rd_addr),      32'(e.addr));
                check("rd_ptr_gray",  32'(bus.rd_ptr_gray),  32'(e.gray));
                check("empty",        32'(bus.empty),        32'(e.empty));
                check("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
                check("rd_level",     32'(bus.rd_level),     32'(e.level));
                check("underflow",    32'(bus.underflow),    32'(e.uf));
                checks++;
                if ($countones(bus.rd_ptr_gray ^ prev_gray) > 1) begin
                    errors++;
                    $display("FAIL gray_hamming actual=%0d bits changed, required<=1 at %0t",
                             $countones(bus.rd_ptr_gray ^ prev_gray), $time);
                end
                prev_gray = bus.rd_ptr_gray;
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit re;
        bus.rd_en       = 1'b0;
        bus.wr_ptr_gray = '0;
        model_reset();

        // Reset state, then an underflow attempt on the empty FIFO.
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(1'b0, 0);
        step(1'b1, 0);
        step(1'b0, 0);
        step(1'b0, 0);

        // One word: visible two edges after it is driven.
        wtot = 1;
        repeat (4) step(1'b0, wtot);

        // Full FIFO, then four back-to-back reads.
        wtot = 4;
        repeat (3) step(1'b0, wtot);
        repeat (4) step(1'b1, wtot);
        repeat (2) step(1'b0, wtot);

        // Fill/drain rounds carry the pointer through several wraps.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wtot++;
                step(1'b0, wtot);
            end
            repeat (8) step(1'b1, wtot);
        end

        // Random mix of reads and writes, never overfilling.
        repeat (400) begin
            re = 1'($urandom % 2);
            if (($urandom % 2 == 1) && (wtot - rd_tot < DEPTH)) wtot++;
            step(re, wtot);
        end

        // Simultaneous write arrival and read at level 1.
        repeat (8) step(1'b1, wtot);
        wtot++;
        repeat (3) step(1'b0, wtot);
        check("simul_pre_level", 32'(bus.rd_level), 32'd1);
        wtot++;
        step(1'b1, wtot);
        repeat (4) step(1'b0, wtot);
        check("simul_post_level", 32'(bus.rd_level), 32'd1);
        check("simul_post_empty", 32'(bus.empty), 32'd0);

        // Asynchronous reset mid-drain at level 3.
        repeat (3) step(1'b1, wtot);
        wtot += 4;
        repeat (3) step(1'b0, wtot);
        step(1'b1, wtot);
        check("pre_reset_level", 32'(bus.rd_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        bus.rd_en       = 1'b0;
        bus.wr_ptr_gray = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b0, 0);
        wtot = 2;
        repeat (3) step(1'b0, wtot);
        repeat (3) step(1'b1, wtot);
        step(1'b0, wtot);

        // Every prediction must have been consumed by the monitor.
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_read_ctrl
